// File: rtl/paddle_adc_pkg.sv
// Shared definitions for the paddle ADC scanner: FSM state encoding,
// default geometry constants and the mux-select width helper.
// Optional feature macro: PADDLE_DEADBAND_EN (jitter deadband on updates).
package paddle_adc_pkg;

   // Scanner FSM states
   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      ACCUM  = 2'd1,
      UPDATE = 2'd2
   } state_e;

   // Default geometry of the original two-player board
   localparam int DEF_ADC_W     = 9;
   localparam int DEF_POS_W     = 10;
   localparam int DEF_Y_MAX     = 400;
   localparam int DEF_RESET_POS = 240;

   // Build-time switch for the deadband filter
`ifdef PADDLE_DEADBAND_EN
   localparam bit DEADBAND_EN = 1'b1;
`else
   localparam bit DEADBAND_EN = 1'b0;
`endif

   // Mux select width: at least one bit, even for a single channel
   function automatic int sel_w(input int n);
      if (n <= 1) return 1;
      else return $clog2(n);
   endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Sample accumulator for one conversion: sums 2^AVG_LOG2 consecutive ADC
// samples while en is high, flags the last one with done, and presents the
// truncated average clamped to Y_MAX as result. clear empties it.
module adc_avg_accum
   import paddle_adc_pkg::*;
#(
   parameter int ADC_W    = DEF_ADC_W,
   parameter int POS_W    = DEF_POS_W,
   parameter int AVG_LOG2 = 2,
   parameter int Y_MAX    = DEF_Y_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [ADC_W-1:0] adc,
   output logic             done,
   output logic [POS_W-1:0] result
);

   // Sum of 2^AVG_LOG2 samples of ADC_W bits never exceeds ADC_W+AVG_LOG2 bits
   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [POS_W-1:0] Y_MAX_P  = POS_W'(Y_MAX);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [ADC_W-1:0] avg;
   logic [POS_W-1:0] avg_ext;

   // Accumulate samples and count them; the counter wraps after the last one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (en) begin
         acc <= acc + ACC_W'(adc);
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   // The sample being added this cycle is the last of the conversion
   assign done = en && (cnt == CNT_LAST);

   // Truncating average, widened to the position width and clamped
   always_comb begin
      avg     = ADC_W'(acc >> AVG_LOG2);
      avg_ext = POS_W'(avg);
      result  = (avg_ext > Y_MAX_P) ? Y_MAX_P : avg_ext;
   end

endmodule

// File: rtl/paddle_adc_scanner.sv
// Multi-channel paddle ADC scanner. Steps the external analog mux through
// NUM_CH channels; for each it waits SETTLE_CYCLES, averages 2^AVG_LOG2
// samples, clamps to Y_MAX and publishes a registered position.
// Optional feature macro: PADDLE_DEADBAND_EN -- when defined, a channel is
// only rewritten (and strobed) if the new result differs from the held
// position by more than DEADBAND.
//
// Output strobe: pos_valid[k] is high for exactly one cycle when pos slice k
// has just been written; there is no ready/back-pressure, so a consumer must
// take the slice in that cycle (the slice then holds until its next update).
// At most one pos_valid bit is high at a time.
module paddle_adc_scanner
   import paddle_adc_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int ADC_W         = DEF_ADC_W,
   parameter int POS_W         = DEF_POS_W,
   parameter int SETTLE_CYCLES = 262144,
   parameter int AVG_LOG2      = 2,
   parameter int Y_MAX         = DEF_Y_MAX,
   parameter int RESET_POS     = DEF_RESET_POS,
   parameter int DEADBAND      = 2,
   localparam int SEL_W        = sel_w(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADC_W-1:0]        adc,
   input  logic                    freeze,
   output logic [SEL_W-1:0]        sel,
   output logic [NUM_CH*POS_W-1:0] pos,
   output logic [NUM_CH-1:0]       pos_valid,
   output logic [1:0]              dbg_state
);

   localparam int SCNT_W = (SETTLE_CYCLES <= 1) ? 1 : $clog2(SETTLE_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_RELOAD = SCNT_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0]  SEL_LAST    = SEL_W'(NUM_CH - 1);
   localparam logic [POS_W-1:0]  RESET_P     = POS_W'(RESET_POS);
   localparam logic [POS_W-1:0]  DEADBAND_P  = POS_W'(DEADBAND);

   state_e                         state;
   logic [SCNT_W-1:0]              settle_cnt;
   logic [NUM_CH-1:0][POS_W-1:0]   pos_q;
   logic                           acc_clear;
   logic                           acc_en;
   logic                           acc_done;
   logic [POS_W-1:0]               result;
   logic [POS_W-1:0]               pos_cur;
   logic [POS_W-1:0]               diff;
   logic                           write_en;

   // Accumulate only while in ACCUM; empty it as the conversion is published
   assign acc_en    = (state == ACCUM);
   assign acc_clear = (state == UPDATE);

   adc_avg_accum #(
      .ADC_W    (ADC_W),
      .POS_W    (POS_W),
      .AVG_LOG2 (AVG_LOG2),
      .Y_MAX    (Y_MAX)
   ) u_accum (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .en     (acc_en),
      .adc    (adc),
      .done   (acc_done),
      .result (result)
   );

   // Decide whether this conversion rewrites the selected channel
   always_comb begin
      pos_cur  = pos_q[sel];
      diff     = (result > pos_cur) ? (result - pos_cur) : (pos_cur - result);
      write_en = !DEADBAND_EN || (diff > DEADBAND_P);
   end

   // Scan FSM: settle after each mux change, accumulate, then publish and advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SETTLE;
         settle_cnt <= SCNT_RELOAD;
         sel        <= '0;
         pos_q      <= {NUM_CH{RESET_P}};
         pos_valid  <= '0;
      end else begin
         pos_valid <= '0;
         case (state)
            SETTLE: begin
               // A freeze only holds us at the end of settling, so a
               // conversion is never split by a pause
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - 1'b1;
               end else if (!freeze) begin
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (acc_done) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               if (write_en) begin
                  pos_q[sel]     <= result;
                  pos_valid[sel] <= 1'b1;
               end
               sel        <= (sel == SEL_LAST) ? '0 : sel + 1'b1;
               settle_cnt <= SCNT_RELOAD;
               state      <= SETTLE;
            end
            default: begin
               state      <= SETTLE;
               settle_cnt <= SCNT_RELOAD;
            end
         endcase
      end
   end

   assign pos       = pos_q;
   assign dbg_state = state;

endmodule
